uart_tx_fifo: RTL and testbench

Byte buffer and issue sequencer directly upstream of uart_transmitter. Host logic pushes bytes at any rate. The block drains them in order onto Tx_DATA/Tx_WR using the transmitter's Tx_BUSY handshake. This lets the host source bursts without polling Tx_BUSY. Same clock domain as the transmitter (clk1 at system level).

---
 rtl/uart_tx_fifo_pkg.sv | 33 +++
 rtl/uart_tx_fifo_if.sv | 36 +++
 rtl/uart_tx_fifo_mem.sv | 85 ++++++++
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared issue-FSM state encoding and defaults for uart_tx_fifo.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  // Issue FSM encoding, 2 bits wide
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_HI = 2'd2;
  localparam logic [1:0] ST_WAIT_LO = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    WAIT_HI = ST_WAIT_HI,
    WAIT_LO = ST_WAIT_LO
  } tx_state_e;

  // Cycles to wait for Tx_BUSY after a strobe before re-strobing
  localparam int BUSY_WAIT_DEFAULT = 4;

  // Retry counter only has to reach busy_wait-1; keep at least one bit
  function automatic int retry_cnt_width(input int busy_wait);
    return (busy_wait < 2) ? 1 : $clog2(busy_wait);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_fifo_if
// Brief   : Host push port, status and transmitter handshake of uart_tx_fifo.
//           slave  = the FIFO/sequencer, master = host + transmitter side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int ADDR_W = 3
) ();

  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              Tx_BUSY;
  logic              Tx_WR;
  logic [7:0]        Tx_DATA;
  logic              overflow;
  logic              ovf_clr;

  modport slave (
    input  wr_en, wr_data, Tx_BUSY, ovf_clr,
    output full, empty, count, Tx_WR, Tx_DATA, overflow
  );

  modport master (
    output wr_en, wr_data, Tx_BUSY, ovf_clr,
    input  full, empty, count, Tx_WR, Tx_DATA, overflow
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
//------------------------------------------------------------------------------
// Module  : fifo_mem_sync
// Brief   : DEPTH x 8 synchronous FIFO storage with registered full/empty/count.
//           A push while full is accepted only when a pop happens in the same
//           cycle; otherwise it is silently dropped.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_mem_sync #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [7:0]        wr_data_i,
  output logic [7:0]        rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q,  count_d;
  logic                full_q,   full_d;
  logic                empty_q,  empty_d;
  logic                push_acc;
  logic                pop_acc;

  // Acceptance, pointer and occupancy next-state
  always_comb begin
    pop_acc  = pop_i && !empty_q;
    push_acc = push_i && (!full_q || pop_acc);
    wr_ptr_d = push_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  // Pointers, count and flags; flags registered alongside the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Read port shows the head entry; when full with a simultaneous push the
  // old head is read before the same slot is overwritten at the edge
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_fifo
// Brief   : Byte FIFO plus issue sequencer feeding uart_transmitter through
//           the Tx_WR / Tx_DATA / Tx_BUSY handshake. Re-strobes the same byte
//           if Tx_BUSY never rises within BUSY_WAIT cycles.
//           Optional macro UART_TX_FIFO_OVF_EN adds a sticky overflow flag.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave tx_if
);

  localparam int                 RETRY_W    = retry_cnt_width(BUSY_WAIT);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(BUSY_WAIT - 1);

  tx_state_e          state_q,   state_d;
  logic [RETRY_W-1:0] retry_q,   retry_d;
  logic               tx_wr_q,   tx_wr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               pop;
  logic [7:0]         fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ADDR_W:0]    fifo_count;

  fifo_mem_sync #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (tx_if.wr_en),
    .pop_i     (pop),
    .wr_data_i (tx_if.wr_data),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Issue FSM next-state: pop only from IDLE with the transmitter free
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_if.Tx_BUSY) begin
          pop       = 1'b1;
          tx_data_d = fifo_rd_data;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        retry_d = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_if.Tx_BUSY) begin
          state_d = WAIT_LO;
        end else if (retry_q == RETRY_LAST) begin
          // Transmitter never took the byte (e.g. disabled): strobe it again
          state_d = ISSUE;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_if.Tx_BUSY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_wr_d = (state_d == ISSUE);
  end

  // FSM state, retry counter and registered transmitter outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      retry_q   <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_if.Tx_WR   = tx_wr_q;
  assign tx_if.Tx_DATA = tx_data_q;
  assign tx_if.full    = fifo_full;
  assign tx_if.empty   = fifo_empty;
  assign tx_if.count   = fifo_count;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;
  logic drop;

  // A dropped push sets the flag; set takes priority over clear
  always_comb begin
    drop  = tx_if.wr_en && fifo_full && !pop;
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (tx_if.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Sticky overflow register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign tx_if.overflow = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = tx_if.ovf_clr;
  assign tx_if.overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_tx_fifo
// Brief   : Self-checking bench for uart_tx_fifo with a simple transmitter
//           model (Tx_BUSY rises the cycle after a strobe, lasts FRAME cycles).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo;

  localparam int FRAME = 6;
`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       clr;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(3)) bus ();

  logic       force_busy = 1'b0;
  logic       tx_en      = 1'b1;
  logic       m_busy     = 1'b0;
  logic       prev_wr    = 1'b0;
  int         frame_cnt  = 0;
  logic [7:0] cur_byte   = 8'h00;
  int         cyc        = 0;
  int         proto_err  = 0;
  int         wr_times[$];
  logic [7:0] wr_log[$];
  int         checks     = 0;
  int         errors     = 0;
  vec_t       tbl[13];

  assign bus.Tx_BUSY = m_busy | force_busy;

  uart_tx_fifo #(
    .DEPTH     (8),
    .ADDR_W    (3),
    .BUSY_WAIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tx_if (bus)
  );

  // Transmitter model and strobe monitor
  always @(posedge clk) begin
    logic bad;
    cyc <= cyc + 1;
    if (bus.Tx_WR === 1'b1) begin
      wr_times.push_back(cyc);
      wr_log.push_back(bus.Tx_DATA);
    end
    bad = (m_busy && reset && (bus.Tx_WR === 1'b1 || bus.Tx_DATA !== cur_byte))
       || (force_busy && bus.Tx_WR === 1'b1)
       || (prev_wr && bus.Tx_WR === 1'b1);
    if (bad) proto_err <= proto_err + 1;
    prev_wr <= (bus.Tx_WR === 1'b1);
    if (!reset) begin
      m_busy    <= 1'b0;
      frame_cnt <= 0;
    end else if (m_busy) begin
      if (frame_cnt == FRAME - 1) begin
        m_busy    <= 1'b0;
        frame_cnt <= 0;
      end else begin
        frame_cnt <= frame_cnt + 1;
      end
    end else if (bus.Tx_WR === 1'b1 && tx_en) begin
      m_busy   <= 1'b1;
      cur_byte <= bus.Tx_DATA;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
  endtask

  task automatic idle_in;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  function automatic int count_byte(input logic [7:0] b);
    int n = 0;
    foreach (wr_log[i]) if (wr_log[i] == b) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] exp_order[9];
    int n;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'hFF, 1'b0, 4'd8, 1'b1, 1'b0, OVF_ON};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, OVF_ON};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'hFF, 1'b1, 4'd8, 1'b1, 1'b0, OVF_ON};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    exp_order = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};

    // Reset state
    reset       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst empty", bus.empty, 1);
    chk("rst full", bus.full, 0);
    chk("rst count", bus.count, 0);
    chk("rst Tx_WR", bus.Tx_WR, 0);
    chk("rst Tx_DATA", bus.Tx_DATA, 8'h00);
    chk("rst overflow", bus.overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    wr_log.delete();
    wr_times.delete();

    // Single byte: two-cycle latency, one strobe
    push(8'hA5);
    @(posedge clk); #1;
    chk("A5 count after push", bus.count, 1);
    chk("A5 empty after push", bus.empty, 0);
    chk("A5 no early Tx_WR", bus.Tx_WR, 0);
    idle_in();
    @(posedge clk); #1;
    chk("A5 Tx_WR", bus.Tx_WR, 1);
    chk("A5 Tx_DATA", bus.Tx_DATA, 8'hA5);
    chk("A5 empty after pop", bus.empty, 1);
    @(posedge clk); #1;
    chk("A5 Tx_WR one cycle", bus.Tx_WR, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("A5 strobe count", wr_log.size(), 1);
    chk("A5 logged byte", wr_log[0], 8'hA5);
    chk("A5 Tx_DATA held", bus.Tx_DATA, 8'hA5);

    // Fill / drop / overflow table with transmitter held busy
    @(negedge clk);
    force_busy = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.wr_en   = tbl[i].wr_en;
      bus.wr_data = tbl[i].data;
      bus.ovf_clr = tbl[i].clr;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d count", i), bus.count, tbl[i].exp_count);
      chk($sformatf("tbl%0d full", i), bus.full, tbl[i].exp_full);
      chk($sformatf("tbl%0d empty", i), bus.empty, tbl[i].exp_empty);
      chk($sformatf("tbl%0d overflow", i), bus.overflow, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d Tx_WR", i), bus.Tx_WR, 0);
    end

    // Full with a same-cycle pop: push of 55 is accepted
    @(negedge clk);
    wr_log.delete();
    force_busy  = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h55;
    @(posedge clk); #1;
    chk("pp count", bus.count, 8);
    chk("pp full", bus.full, 1);
    chk("pp Tx_WR", bus.Tx_WR, 1);
    chk("pp Tx_DATA", bus.Tx_DATA, 8'h01);
    chk("pp overflow", bus.overflow, 0);
    idle_in();
    for (int i = 0; i < 400 && wr_log.size() < 9; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("order strobes", wr_log.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("order byte%0d", i), wr_log[i], exp_order[i]);
    chk("order empty", bus.empty, 1);

    // Transmitter disabled: periodic re-strobe without new pops
    @(negedge clk);
    wr_log.delete();
    wr_times.delete();
    tx_en = 1'b0;
    push(8'h3C);
    push(8'h3D);
    idle_in();
    repeat (16) @(posedge clk);
    #1;
    chk("retry count held", bus.count, 1);
    chk("retry strobes>=3", wr_log.size() >= 3, 1);
    chk("retry period 1", wr_times[1] - wr_times[0], 5);
    chk("retry period 2", wr_times[2] - wr_times[1], 5);
    chk("retry data0", wr_log[0], 8'h3C);
    chk("retry data2", wr_log[2], 8'h3C);
    chk("retry Tx_DATA", bus.Tx_DATA, 8'h3C);
    @(negedge clk);
    tx_en = 1'b1;
    for (int i = 0; i < 100 && count_byte(8'h3D) == 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk("retry 3D once", count_byte(8'h3D), 1);
    chk("retry last byte", wr_log[wr_log.size() - 1], 8'h3D);
    chk("retry drained", bus.count, 0);

    // Asynchronous reset in WAIT_LO with three bytes queued
    @(negedge clk);
    wr_log.delete();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    idle_in();
    @(posedge clk); #1;
    chk("mid count", bus.count, 3);
    chk("mid busy", bus.Tx_BUSY, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst count", bus.count, 0);
    chk("arst empty", bus.empty, 1);
    chk("arst full", bus.full, 0);
    chk("arst Tx_WR", bus.Tx_WR, 0);
    chk("arst Tx_DATA", bus.Tx_DATA, 8'h00);
    chk("arst overflow", bus.overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = wr_log.size();
    repeat (20) @(posedge clk);
    #1;
    chk("post-rst no strobe", wr_log.size(), n);
    push(8'h5A);
    idle_in();
    for (int i = 0; i < 30 && wr_log.size() == n; i++) @(posedge clk);
    #1;
    chk("post-rst strobes", wr_log.size(), n + 1);
    chk("post-rst byte", wr_log[wr_log.size() - 1], 8'h5A);

    repeat (10) @(posedge clk);
    chk("handshake protocol", proto_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
